mips_mc_controller: RTL

- Main control FSM for the multi-cycle MIPS datapath.
- Decodes opcode/funct, then sequences every datapath mux select and write enable state by state: PC source, memory address source, ALU operand A/B, register destination, write-back source.
- Sits beside the datapath. Takes the instruction-register fields and the ALU zero flag; drives every select/enable the datapath consumes.

---
 rtl/mips_ctrl_pkg.sv | 76 +++++++
 rtl/mips_mc_controller_if.sv | 34 +++
 rtl/mips_alu_decoder.sv | 29 ++
 rtl/mips_mc_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs
// and every datapath select value the controller drives.
package mips_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FN_W     = 6;
    localparam int unsigned ALUC_W   = 3;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FN_W-1:0] FN_JR    = 6'b001000;
    localparam logic [FN_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND   = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR    = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] WB_MDR     = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC      = 2'b10;

    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_REG = 1'b1;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BR    = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_REG    = 2'b11;

    localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
    } state_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, all selects/enables out.
interface mips_mc_controller_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic [FN_W-1:0]   funct;
    logic              zero;

    logic              pc_en;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic [SEL_W-1:0]  reg_dst;
    logic [SEL_W-1:0]  mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [SEL_W-1:0]  alu_src_b;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [SEL_W-1:0]  pc_src;
    logic              instr_done;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// Maps the controller's coarse ALU request (add/sub/slt/from-funct) to the ALU control code.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FN_W-1:0]    funct,
    output logic [ALUC_W-1:0]  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_SLT: alu_ctrl = ALU_SLT;
            default: begin
                // Unrecognised functs fall back to add
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS main control FSM: Moore decode of every datapath select/enable
// from the current state; pc_en also folds in the ALU zero flag for branches.
module mips_mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mips_mc_controller_if.master bus
);

    state_t state;
    state_t state_next;

    logic               pc_write;
    logic               pc_write_cond;
    logic               mem_read_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               reg_write_s;
    logic               done_s;
    logic               i_or_d_s;
    logic               alu_src_a_s;
    logic [SEL_W-1:0]   alu_src_b_s;
    logic [SEL_W-1:0]   reg_dst_s;
    logic [SEL_W-1:0]   mem_to_reg_s;
    logic [SEL_W-1:0]   pc_src_s;
    logic               alu_use;
    logic [ALUOP_W-1:0] alu_op;
    logic [ALUC_W-1:0]  alu_dec;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        done_s        = 1'b0;
        i_or_d_s      = 1'b0;
        alu_src_a_s   = SRCA_PC;
        alu_src_b_s   = SRCB_B;
        reg_dst_s     = REG_DST_RT;
        mem_to_reg_s  = WB_ALUOUT;
        pc_src_s      = PCSRC_ALU;
        alu_use       = 1'b0;
        alu_op        = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                ir_write_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                alu_use     = 1'b1;
                pc_write    = 1'b1;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut
                alu_src_b_s = SRCB_BR;
                alu_use     = 1'b1;
                case (bus.opcode)
                    OP_LW, OP_SW:    state_next = S_MEM_ADDR;
                    OP_RTYPE:        state_next = (bus.funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_SLTI: state_next = S_I_EXEC;
                    OP_BEQ:          state_next = S_BRANCH;
                    OP_J:            state_next = S_JUMP;
                    OP_JAL:          state_next = S_JAL;
                    default: begin
                        done_s     = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_s = SRCA_REG;
                alu_src_b_s = SRCB_IMM;
                alu_use     = 1'b1;
                state_next  = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
                state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg_s = WB_MDR;
                reg_write_s  = 1'b1;
                done_s       = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
                done_s      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a_s = SRCA_REG;
                alu_use     = 1'b1;
                alu_op      = ALUOP_FUNCT;
                state_next  = S_R_WB;
            end
            S_R_WB: begin
                reg_dst_s   = REG_DST_RD;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_s = SRCA_REG;
                alu_src_b_s = SRCB_IMM;
                alu_use     = 1'b1;
                alu_op      = (bus.opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                state_next  = S_I_WB;
            end
            S_I_WB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s   = SRCA_REG;
                alu_use       = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src_s      = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                done_s        = 1'b1;
            end
            S_JUMP: begin
                pc_src_s = PCSRC_JUMP;
                pc_write = 1'b1;
                done_s   = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, which is the link value
                pc_src_s     = PCSRC_JUMP;
                pc_write     = 1'b1;
                reg_dst_s    = REG_DST_RA;
                mem_to_reg_s = WB_PC;
                reg_write_s  = 1'b1;
                done_s       = 1'b1;
            end
            S_JR: begin
                pc_src_s = PCSRC_REG;
                pc_write = 1'b1;
                done_s   = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .alu_op   (alu_op),
        .funct    (bus.funct),
        .alu_ctrl (alu_dec)
    );

    // Enables are squashed during reset so an aborted instruction cannot commit
    assign bus.pc_en      = !rst && (pc_write || (pc_write_cond && bus.zero));
    assign bus.mem_read   = !rst && mem_read_s;
    assign bus.mem_write  = !rst && mem_write_s;
    assign bus.ir_write   = !rst && ir_write_s;
    assign bus.reg_write  = !rst && reg_write_s;
    assign bus.instr_done = !rst && done_s;

    assign bus.i_or_d     = i_or_d_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.alu_ctrl   = alu_use ? alu_dec : ALUC_W'(0);

endmodule
